// File: rtl/uart_rx_oversampled.sv
// UART receiver: 2-flop rx synchroniser, oversampled mid-bit sampling, false-start rejection, framing error.
// Optional parity stage when UART_RX_PARITY_EN is defined (adds PARITY_ODD and parity_error).
module uart_rx_oversampled #(
    parameter int DBITS   = 8,
    parameter int SB_TICK = 16,
    parameter int OS_RATE = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             sample_tick,
    input  logic             rx,
    output logic [DBITS-1:0] data_out,
    output logic             data_ready,
    output logic             framing_error,
    output logic             busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic             parity_error
`endif
);

    localparam int TW = $clog2((OS_RATE > SB_TICK) ? OS_RATE : SB_TICK);
    localparam int BW = (DBITS > 1) ? $clog2(DBITS) : 1;

    localparam logic [TW-1:0] MID_START = TW'(OS_RATE / 2 - 1);
    localparam logic [TW-1:0] MID_BIT   = TW'(OS_RATE - 1);
    localparam logic [TW-1:0] MID_STOP  = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DBITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state, state_nxt;
    logic             rx_meta, rx_s;
    logic [TW-1:0]    tick_cnt, tick_nxt;
    logic [BW-1:0]    bit_cnt, bit_nxt;
    logic [DBITS-1:0] shift, shift_nxt, data_nxt;
    logic             ready_nxt, ferr_nxt;
`ifdef UART_RX_PARITY_EN
    logic             par_bit, par_nxt, perr_nxt, par_bad;

    // Expected parity bit makes the total count of ones even (or odd when PARITY_ODD).
    assign par_bad = (par_bit != ((^shift) ^ PARITY_ODD));
`endif

    // Synchroniser flops reset to the idle line level so release never looks like a start edge.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            shift         <= '0;
            data_out      <= '0;
            data_ready    <= 1'b0;
            framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit       <= 1'b0;
            parity_error  <= 1'b0;
`endif
        end else begin
            state         <= state_nxt;
            tick_cnt      <= tick_nxt;
            bit_cnt       <= bit_nxt;
            shift         <= shift_nxt;
            data_out      <= data_nxt;
            data_ready    <= ready_nxt;
            framing_error <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
            par_bit       <= par_nxt;
            parity_error  <= perr_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        data_nxt  = data_out;
        ready_nxt = 1'b0;
        ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nxt   = par_bit;
        perr_nxt  = 1'b0;
`endif
        case (state)
            // Start edge is watched every clock so detection is not quantised to the tick.
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    tick_nxt  = '0;
                end
            end
            START: begin
                if (sample_tick) begin
                    if (tick_cnt == MID_START) begin
                        if (!rx_s) begin
                            state_nxt = DATA;
                            tick_nxt  = '0;
                            bit_nxt   = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (sample_tick) begin
                    if (tick_cnt == MID_BIT) begin
                        shift_nxt = {rx_s, shift[DBITS-1:1]};
                        tick_nxt  = '0;
                        if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_nxt = PARITY;
`else
                            state_nxt = STOP;
`endif
                        end else begin
                            bit_nxt = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (sample_tick) begin
                    if (tick_cnt == MID_BIT) begin
                        par_nxt   = rx_s;
                        tick_nxt  = '0;
                        state_nxt = STOP;
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
            end
`endif
            // Leaving mid stop bit lets a back-to-back start edge be caught without loss.
            STOP: begin
                if (sample_tick) begin
                    if (tick_cnt == MID_STOP) begin
                        state_nxt = IDLE;
                        if (!rx_s) begin
                            ferr_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (par_bad) begin
                            perr_nxt = 1'b1;
`endif
                        end else begin
                            ready_nxt = 1'b1;
                            data_nxt  = shift;
                        end
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: scaled bit timing (tick every 4 clks, 64 clks per bit),
// frame-level reference model predicting each output pulse and the value data_out must hold.
module tb_uart_rx_oversampled;

    localparam int TICK_CLKS = 4;
    localparam int BIT_CLKS  = 16 * TICK_CLKS;
`ifdef UART_RX_PARITY_EN
    localparam bit         PAR_EN     = 1'b1;
    localparam int         FRAME_BITS = 11;
    localparam logic [7:0] BREAK_TAIL = 8'hF8;
`else
    localparam bit         PAR_EN     = 1'b0;
    localparam int         FRAME_BITS = 10;
    localparam logic [7:0] BREAK_TAIL = 8'hE0;
`endif

    logic       clk_100MHz  = 1'b0;
    logic       reset       = 1'b1;
    logic       sample_tick = 1'b0;
    logic       rx          = 1'b1;
    logic [7:0] data_out;
    logic       data_ready, framing_error, busy, perr_obs;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         overlap = 0;
    bit         tick_always = 1'b0;
    int         tick_div = 0;
    logic [7:0] exp_last = 8'h00;

    // Observed pulses (kind 0 = data_ready, 1 = framing_error, 2 = parity_error) and predictions.
    int ev_kind[$];
    int ev_data[$];
    int ev_cyc[$];
    int exp_kind[$];
    int exp_data[$];

`ifdef UART_RX_PARITY_EN
    logic parity_error;
    assign perr_obs = parity_error;
`else
    assign perr_obs = 1'b0;
`endif

    uart_rx_oversampled dut (
        .clk_100MHz    (clk_100MHz),
        .reset         (reset),
        .sample_tick   (sample_tick),
        .rx            (rx),
        .data_out      (data_out),
        .data_ready    (data_ready),
        .framing_error (framing_error),
        .busy          (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_error  (parity_error)
`endif
    );

    always #5 clk_100MHz = ~clk_100MHz;

    initial forever begin
        @(negedge clk_100MHz);
        tick_div    = (tick_div == TICK_CLKS - 1) ? 0 : tick_div + 1;
        sample_tick = tick_always || (tick_div == 0);
    end

    initial forever begin
        @(posedge clk_100MHz);
        #1;
        cyc++;
        if (data_ready) begin
            ev_kind.push_back(0); ev_data.push_back(int'(data_out)); ev_cyc.push_back(cyc);
        end
        if (framing_error) begin
            ev_kind.push_back(1); ev_data.push_back(int'(data_out)); ev_cyc.push_back(cyc);
        end
        if (perr_obs) begin
            ev_kind.push_back(2); ev_data.push_back(int'(data_out)); ev_cyc.push_back(cyc);
        end
        if (int'(data_ready) + int'(framing_error) + int'(perr_obs) > 1) overlap++;
    end

    // Frame-level outcome: bad stop wins, then bad parity, else the byte is delivered.
    function automatic void model_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
        if (!stop_ok) begin
            exp_kind.push_back(1); exp_data.push_back(int'(exp_last));
        end else if (PAR_EN && !par_ok) begin
            exp_kind.push_back(2); exp_data.push_back(int'(exp_last));
        end else begin
            exp_last = b;
            exp_kind.push_back(0); exp_data.push_back(int'(b));
        end
    endfunction

    function automatic void clear_queues();
        ev_kind.delete(); ev_data.delete(); ev_cyc.delete();
        exp_kind.delete(); exp_data.delete();
    endfunction

    task automatic send_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk_100MHz);
    endtask

    // A bad stop bit is held low for 3/4 of a bit so the receiver's restart sees a clean false start.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok, input int bc);
        send_bit(1'b0, bc);
        for (int i = 0; i < 8; i++) send_bit(b[i], bc);
        if (PAR_EN) send_bit((^b) ^ ~par_ok, bc);
        if (stop_ok) begin
            send_bit(1'b1, bc);
        end else begin
            send_bit(1'b0, bc * 3 / 4);
            send_bit(1'b1, bc - bc * 3 / 4);
        end
    endtask

    task automatic idle(input int nbits);
        rx = 1'b1;
        repeat (nbits * BIT_CLKS) @(negedge clk_100MHz);
    endtask

    task automatic test_reset();
        clear_queues();
        rx = 1'b0;
        repeat (5) @(negedge clk_100MHz);
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out: got %02h want 00", data_out); end
        total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL reset_data_ready: got %b want 0", data_ready); end
        total++; if (framing_error !== 1'b0) begin bad++; $display("FAIL reset_framing_error: got %b want 0", framing_error); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (perr_obs !== 1'b0) begin bad++; $display("FAIL reset_parity_error: got %b want 0", perr_obs); end
        rx = 1'b1;
        repeat (3) @(negedge clk_100MHz);
        reset = 1'b0;
        repeat (8) @(negedge clk_100MHz);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_release_busy: got %b want 0", busy); end
        total++; if (ev_kind.size() !== 0) begin bad++; $display("FAIL reset_pulses: got %0d want 0", ev_kind.size()); end
    endtask

    task automatic test_basic();
        int k, d, ek, ed;
        clear_queues();
        model_frame(8'h55, 1'b1, 1'b1);
        send_frame(8'h55, 1'b1, 1'b1, BIT_CLKS);
        idle(2);
        total++;
        if (ev_kind.size() !== exp_kind.size()) begin
            bad++; $display("FAIL basic_count: got %0d pulses want %0d", ev_kind.size(), exp_kind.size());
        end
        while (ev_kind.size() > 0 && exp_kind.size() > 0) begin
            k = ev_kind.pop_front(); d = ev_data.pop_front(); ek = exp_kind.pop_front(); ed = exp_data.pop_front();
            total++;
            if (k !== ek || d !== ed) begin
                bad++; $display("FAIL basic_event: got kind=%0d data=%02h want kind=%0d data=%02h", k, d, ek, ed);
            end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int k, d, ek, ed, gap;
        clear_queues();
        model_frame(8'hA3, 1'b1, 1'b1);
        model_frame(8'h0F, 1'b1, 1'b1);
        send_frame(8'hA3, 1'b1, 1'b1, BIT_CLKS);
        send_frame(8'h0F, 1'b1, 1'b1, BIT_CLKS);
        idle(2);
        total++;
        if (ev_kind.size() !== exp_kind.size()) begin
            bad++; $display("FAIL b2b_count: got %0d pulses want %0d", ev_kind.size(), exp_kind.size());
        end
        if (ev_cyc.size() >= 2) begin
            gap = ev_cyc[1] - ev_cyc[0];
            total++;
            if (gap < FRAME_BITS * BIT_CLKS - TICK_CLKS || gap > FRAME_BITS * BIT_CLKS + TICK_CLKS) begin
                bad++; $display("FAIL b2b_spacing: got %0d clks want %0d +/- %0d", gap, FRAME_BITS * BIT_CLKS, TICK_CLKS);
            end
        end
        while (ev_kind.size() > 0 && exp_kind.size() > 0) begin
            k = ev_kind.pop_front(); d = ev_data.pop_front(); ek = exp_kind.pop_front(); ed = exp_data.pop_front();
            total++;
            if (k !== ek || d !== ed) begin
                bad++; $display("FAIL b2b_event: got kind=%0d data=%02h want kind=%0d data=%02h", k, d, ek, ed);
            end
        end
    endtask

    task automatic test_false_start();
        bit saw_busy;
        clear_queues();
        saw_busy = 1'b0;
        rx = 1'b0;
        repeat (3 * TICK_CLKS) begin
            @(negedge clk_100MHz);
            if (busy) saw_busy = 1'b1;
        end
        rx = 1'b1;
        repeat (12 * TICK_CLKS) @(negedge clk_100MHz);
        total++; if (saw_busy !== 1'b1) begin bad++; $display("FAIL glitch_detected: busy seen %b want 1", saw_busy); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_back_idle: busy %b want 0", busy); end
        total++; if (ev_kind.size() !== 0) begin bad++; $display("FAIL glitch_pulses: got %0d want 0", ev_kind.size()); end
        total++; if (data_out !== exp_last) begin bad++; $display("FAIL glitch_data_out: got %02h want %02h", data_out, exp_last); end
    endtask

    task automatic test_framing();
        int k, d, ek, ed;
        clear_queues();
        model_frame(8'hFF, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1, BIT_CLKS);
        idle(2);
        total++;
        if (ev_kind.size() !== exp_kind.size()) begin
            bad++; $display("FAIL framing_count: got %0d pulses want %0d", ev_kind.size(), exp_kind.size());
        end
        while (ev_kind.size() > 0 && exp_kind.size() > 0) begin
            k = ev_kind.pop_front(); d = ev_data.pop_front(); ek = exp_kind.pop_front(); ed = exp_data.pop_front();
            total++;
            if (k !== ek || d !== ed) begin
                bad++; $display("FAIL framing_event: got kind=%0d data=%02h want kind=%0d data=%02h", k, d, ek, ed);
            end
        end
        total++; if (data_out !== 8'h0F) begin bad++; $display("FAIL framing_data_kept: got %02h want 0f", data_out); end
    endtask

    task automatic test_reset_midframe();
        int k, d, ek, ed;
        logic [7:0] b;
        clear_queues();
        b = 8'h3C;
        send_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) send_bit(b[i], BIT_CLKS);
        send_bit(b[4], BIT_CLKS / 2);
        reset = 1'b1;
        rx = 1'b1;
        repeat (4) @(negedge clk_100MHz);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b want 0", busy); end
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL midreset_data_out: got %02h want 00", data_out); end
        reset = 1'b0;
        exp_last = 8'h00;
        idle(2);
        model_frame(8'h81, 1'b1, 1'b1);
        send_frame(8'h81, 1'b1, 1'b1, BIT_CLKS);
        idle(2);
        total++;
        if (ev_kind.size() !== exp_kind.size()) begin
            bad++; $display("FAIL midreset_count: got %0d pulses want %0d", ev_kind.size(), exp_kind.size());
        end
        while (ev_kind.size() > 0 && exp_kind.size() > 0) begin
            k = ev_kind.pop_front(); d = ev_data.pop_front(); ek = exp_kind.pop_front(); ed = exp_data.pop_front();
            total++;
            if (k !== ek || d !== ed) begin
                bad++; $display("FAIL midreset_event: got kind=%0d data=%02h want kind=%0d data=%02h", k, d, ek, ed);
            end
        end
    endtask

    // 25 bit periods of break: each failed frame restarts from mid stop bit, so two framing
    // errors occur and the third frame catches the release, giving ones in its upper bits.
    task automatic test_break();
        int k, d, ek, ed;
        clear_queues();
        exp_kind.push_back(1); exp_data.push_back(int'(exp_last));
        exp_kind.push_back(1); exp_data.push_back(int'(exp_last));
        exp_kind.push_back(0); exp_data.push_back(int'(BREAK_TAIL));
        exp_last = BREAK_TAIL;
        rx = 1'b0;
        repeat (25 * BIT_CLKS) @(negedge clk_100MHz);
        idle(8);
        total++;
        if (ev_kind.size() !== exp_kind.size()) begin
            bad++; $display("FAIL break_count: got %0d pulses want %0d", ev_kind.size(), exp_kind.size());
        end
        while (ev_kind.size() > 0 && exp_kind.size() > 0) begin
            k = ev_kind.pop_front(); d = ev_data.pop_front(); ek = exp_kind.pop_front(); ed = exp_data.pop_front();
            total++;
            if (k !== ek || d !== ed) begin
                bad++; $display("FAIL break_event: got kind=%0d data=%02h want kind=%0d data=%02h", k, d, ek, ed);
            end
        end
    endtask

    task automatic test_tick_stuck();
        int k, d, ek, ed;
        logic [7:0] b;
        clear_queues();
        tick_always = 1'b1;
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom_range(0, 255));
            model_frame(b, 1'b1, 1'b1);
            send_frame(b, 1'b1, 1'b1, 16);
        end
        idle(1);
        tick_always = 1'b0;
        idle(1);
        total++;
        if (ev_kind.size() !== exp_kind.size()) begin
            bad++; $display("FAIL stuck_tick_count: got %0d pulses want %0d", ev_kind.size(), exp_kind.size());
        end
        while (ev_kind.size() > 0 && exp_kind.size() > 0) begin
            k = ev_kind.pop_front(); d = ev_data.pop_front(); ek = exp_kind.pop_front(); ed = exp_data.pop_front();
            total++;
            if (k !== ek || d !== ed) begin
                bad++; $display("FAIL stuck_tick_event: got kind=%0d data=%02h want kind=%0d data=%02h", k, d, ek, ed);
            end
        end
    endtask

    task automatic test_random();
        int k, d, ek, ed, gap;
        logic [7:0] b;
        bit stop_ok, par_ok;
        clear_queues();
        overlap = 0;
        for (int i = 0; i < 12; i++) begin
            b       = 8'($urandom_range(0, 255));
            stop_ok = ($urandom_range(0, 3) != 0);
            par_ok  = ($urandom_range(0, 3) != 0);
            gap     = stop_ok ? int'($urandom_range(0, 2)) : 1 + int'($urandom_range(0, 1));
            model_frame(b, stop_ok, par_ok);
            send_frame(b, stop_ok, par_ok, BIT_CLKS);
            idle(gap);
        end
        idle(2);
        total++;
        if (ev_kind.size() !== exp_kind.size()) begin
            bad++; $display("FAIL random_count: got %0d pulses want %0d", ev_kind.size(), exp_kind.size());
        end
        while (ev_kind.size() > 0 && exp_kind.size() > 0) begin
            k = ev_kind.pop_front(); d = ev_data.pop_front(); ek = exp_kind.pop_front(); ed = exp_data.pop_front();
            total++;
            if (k !== ek || d !== ed) begin
                bad++; $display("FAIL random_event: got kind=%0d data=%02h want kind=%0d data=%02h", k, d, ek, ed);
            end
        end
        total++; if (overlap !== 0) begin bad++; $display("FAIL pulse_exclusive: got %0d overlaps want 0", overlap); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int k, d, ek, ed;
        clear_queues();
        model_frame(8'h07, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b0, BIT_CLKS);
        idle(1);
        model_frame(8'h07, 1'b1, 1'b1);
        send_frame(8'h07, 1'b1, 1'b1, BIT_CLKS);
        idle(2);
        total++;
        if (ev_kind.size() !== exp_kind.size()) begin
            bad++; $display("FAIL parity_count: got %0d pulses want %0d", ev_kind.size(), exp_kind.size());
        end
        while (ev_kind.size() > 0 && exp_kind.size() > 0) begin
            k = ev_kind.pop_front(); d = ev_data.pop_front(); ek = exp_kind.pop_front(); ed = exp_data.pop_front();
            total++;
            if (k !== ek || d !== ed) begin
                bad++; $display("FAIL parity_event: got kind=%0d data=%02h want kind=%0d data=%02h", k, d, ek, ed);
            end
        end
    endtask
`endif

    initial begin
        @(negedge clk_100MHz);
        test_reset();
        test_basic();
        test_back_to_back();
        test_false_start();
        test_framing();
        test_reset_midframe();
        test_break();
        test_tick_stuck();
        test_random();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
